// File: rtl/atm_pkg.sv
// Shared constants for the ATM session controller: state encodings, opcodes,
// error codes and small state-classification helpers.
package atm_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_PIN     = 4'd1;
  localparam logic [3:0] ST_HOME    = 4'd2;
  localparam logic [3:0] ST_EXEC    = 4'd3;
  localparam logic [3:0] ST_CONFIRM = 4'd4;
  localparam logic [3:0] ST_PRINT   = 4'd5;
  localparam logic [3:0] ST_EJECT   = 4'd6;

  localparam logic [2:0] OP_EJECT    = 3'd0;
  localparam logic [2:0] OP_BALANCE  = 3'd1;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_DEPOSIT  = 3'd3;
  localparam logic [2:0] OP_TRANSFER = 3'd4;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_INSUFF   = 3'd1;
  localparam logic [2:0] ERR_BAD_ACCT = 3'd2;
  localparam logic [2:0] ERR_BAD_OP   = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;

  // States where the customer is expected to act; only these run the idle timer.
  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == ST_PIN) || (s == ST_HOME);
  endfunction

  // States in which losing the card forces an eject.
  function automatic logic is_session_state(input logic [3:0] s);
    return (s == ST_PIN) || (s == ST_HOME) || (s == ST_EXEC) ||
           (s == ST_CONFIRM) || (s == ST_PRINT);
  endfunction

endpackage

// File: rtl/atm_timeout_ctr.sv
// Idle-cycle counter: counts while enabled, restarts on clear, and flags
// expiry once it has reached TIMEOUT-1 cycles.
module atm_timeout_ctr #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expire = enable && (count_reg == LAST);

endmodule

// File: rtl/atm_txn_controller.sv
// ATM session controller: card/PIN handling with lockout, then balance,
// withdraw, deposit and transfer transactions with receipt and idle timeout.
module atm_txn_controller
  import atm_pkg::*;
#(
  parameter int                BAL_W     = 32,
  parameter int                PIN_W     = 4,
  parameter int                ACCT_W    = 16,
  parameter int                MAX_TRIES = 3,
  parameter int                TIMEOUT   = 1024,
  parameter logic [BAL_W-1:0]  INIT_BAL  = 32'd100000,
  parameter logic [PIN_W-1:0]  CARD_PIN  = 4'hE,
  parameter logic [ACCT_W-1:0] DEST_ACCT = 16'hD903
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              card_in,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin,
  input  logic              op_valid,
  input  logic [2:0]        opcode,
  input  logic [BAL_W-1:0]  amount,
  input  logic [ACCT_W-1:0] acct_no,
  input  logic              receipt_req,
  output logic [BAL_W-1:0]  balance,
  output logic [3:0]        state_o,
  output logic              txn_done,
  output logic              txn_err,
  output logic [2:0]        err_code,
  output logic              print_receipt,
  output logic              card_eject,
  output logic              locked
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRIES_LAST = TRY_W'(MAX_TRIES - 1);

  logic [3:0]        state_reg,    state_next;
  logic [BAL_W-1:0]  balance_reg,  balance_next;
  logic [TRY_W-1:0]  tries_reg,    tries_next;
  logic              locked_reg,   locked_next;
  logic              done_reg,     done_next;
  logic              err_reg,      err_next;
  logic [2:0]        err_code_reg, err_code_next;
  logic              print_reg,    print_next;
  logic              eject_reg,    eject_next;
  logic [2:0]        opcode_reg,   opcode_next;
  logic [BAL_W-1:0]  amount_reg,   amount_next;
  logic [ACCT_W-1:0] acct_reg,     acct_next;
  logic              receipt_reg,  receipt_next;

  logic              tmo_clear;
  logic              tmo_expire;
  logic              card_lost;
  logic [BAL_W:0]    dep_sum;
  logic              can_debit;

  atm_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmo_clear),
    .enable (is_wait_state(state_reg)),
    .expire (tmo_expire)
  );

  assign card_lost = is_session_state(state_reg) && !card_in;
  assign dep_sum   = {1'b0, balance_reg} + {1'b0, amount_reg};
  assign can_debit = (amount_reg <= balance_reg);
  assign tmo_clear = (state_next != state_reg) || pin_valid || op_valid;

  always_comb begin
    state_next    = state_reg;
    balance_next  = balance_reg;
    tries_next    = tries_reg;
    locked_next   = locked_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    err_code_next = ERR_NONE;
    opcode_next   = opcode_reg;
    amount_next   = amount_reg;
    acct_next     = acct_reg;
    receipt_next  = receipt_reg;

    if (card_lost) begin
      // Card pulled mid-session: abandon whatever was in flight.
      state_next = ST_EJECT;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (card_in) begin
            state_next = locked_reg ? ST_EJECT : ST_PIN;
          end
        end

        ST_PIN: begin
          if (pin_valid) begin
            if (pin == CARD_PIN) begin
              state_next = ST_HOME;
              tries_next = '0;
            end else begin
              tries_next = tries_reg + TRY_W'(1);
              if (tries_reg == TRIES_LAST) begin
                locked_next = 1'b1;
                state_next  = ST_EJECT;
              end
            end
          end else if (tmo_expire) begin
            state_next = ST_EJECT;
          end
        end

        ST_HOME: begin
          if (op_valid) begin
            opcode_next  = opcode;
            amount_next  = amount;
            acct_next    = acct_no;
            receipt_next = receipt_req;
            case (opcode)
              OP_EJECT:    state_next = ST_EJECT;
              OP_BALANCE:  state_next = ST_CONFIRM;
              OP_WITHDRAW,
              OP_DEPOSIT,
              OP_TRANSFER: state_next = ST_EXEC;
              default: begin
                err_next      = 1'b1;
                err_code_next = ERR_BAD_OP;
              end
            endcase
          end else if (tmo_expire) begin
            state_next = ST_EJECT;
          end
        end

        ST_EXEC: begin
          case (opcode_reg)
            OP_WITHDRAW: begin
              if (can_debit) balance_next = balance_reg - amount_reg;
              else           err_code_next = ERR_INSUFF;
            end
            OP_DEPOSIT: begin
              if (dep_sum[BAL_W]) err_code_next = ERR_OVERFLOW;
              else                balance_next  = dep_sum[BAL_W-1:0];
            end
            OP_TRANSFER: begin
              if (acct_reg != DEST_ACCT) err_code_next = ERR_BAD_ACCT;
              else if (can_debit)        balance_next  = balance_reg - amount_reg;
              else                       err_code_next = ERR_INSUFF;
            end
            default: err_code_next = ERR_BAD_OP;
          endcase
          if (err_code_next == ERR_NONE) begin
            done_next  = 1'b1;
            state_next = ST_CONFIRM;
          end else begin
            err_next   = 1'b1;
            state_next = ST_HOME;
          end
        end

        ST_CONFIRM: state_next = receipt_reg ? ST_PRINT : ST_HOME;

        ST_PRINT: state_next = ST_HOME;

        ST_EJECT: begin
          state_next = ST_IDLE;
          if (!locked_reg) tries_next = '0;
        end

        default: state_next = ST_IDLE;
      endcase
    end

    // Both pulses fire on entry; neither state can be re-entered from itself.
    eject_next = (state_next == ST_EJECT);
    print_next = (state_next == ST_PRINT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      balance_reg  <= INIT_BAL;
      tries_reg    <= '0;
      locked_reg   <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
      print_reg    <= 1'b0;
      eject_reg    <= 1'b0;
      opcode_reg   <= OP_EJECT;
      amount_reg   <= '0;
      acct_reg     <= '0;
      receipt_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      balance_reg  <= balance_next;
      tries_reg    <= tries_next;
      locked_reg   <= locked_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      print_reg    <= print_next;
      eject_reg    <= eject_next;
      opcode_reg   <= opcode_next;
      amount_reg   <= amount_next;
      acct_reg     <= acct_next;
      receipt_reg  <= receipt_next;
    end
  end

  assign balance       = balance_reg;
  assign state_o       = state_reg;
  assign txn_done      = done_reg;
  assign txn_err       = err_reg;
  assign err_code      = err_code_reg;
  assign print_receipt = print_reg;
  assign card_eject    = eject_reg;
  assign locked        = locked_reg;

endmodule
